// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative M-extension unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic is_div(op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_a(op_e op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_MULHSU) || (op == OP_DIV) ||
               (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(op_e op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result handshake bundle between the execute stage and muldiv_iter.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            kill_i;
    logic            valid_o;
    logic            result_ready_i;
    logic [XLEN-1:0] result_o;

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i,
        input  kill_i, result_ready_i,
        output ready_o, valid_o, result_o
    );

    modport master (
        output start_i, op_i, rs1_i, rs2_i,
        output kill_i, result_ready_i,
        input  ready_o, valid_o, result_o
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Sign correction applied to the magnitude product, quotient or remainder.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic              i_neg_a,
    input  logic              i_neg_b,
    input  op_e               i_op,
    output logic [XLEN-1:0]   o_result
);
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic              w_diff;

    always_comb begin
        w_diff = i_neg_a ^ i_neg_b;
        w_prod = w_diff ? -i_acc : i_acc;
        w_quo  = w_diff ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
        // remainder follows the dividend's sign only
        w_rem  = i_neg_a ? -i_acc[2*XLEN-1:XLEN]
                         : i_acc[2*XLEN-1:XLEN];
        o_result = '0;
        unique case (i_op)
            OP_MUL:    o_result = w_prod[XLEN-1:0];
            OP_MULH:   o_result = w_prod[2*XLEN-1:XLEN];
            OP_MULHSU: o_result = w_prod[2*XLEN-1:XLEN];
            OP_MULHU:  o_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV:    o_result = w_quo;
            OP_DIVU:   o_result = w_quo;
            OP_REM:    o_result = w_rem;
            OP_REMU:   o_result = w_rem;
        endcase
    end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide on magnitudes,
// one bit per cycle, followed by a single sign-fix cycle.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk_i,
    input  logic     reset_i,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    state_e            r_state;
    state_e            w_next;
    op_e               r_op;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_result;

    op_e               w_op;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_accept;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [2*XLEN-1:0] w_div_nxt;
    logic [XLEN-1:0]   w_fix;

    always_comb begin
        w_op    = op_e'(bus.op_i);
        w_neg_a = is_signed_a(w_op) & bus.rs1_i[XLEN-1];
        w_neg_b = is_signed_b(w_op) & bus.rs2_i[XLEN-1];
        w_mag_a = w_neg_a ? -bus.rs1_i : bus.rs1_i;
        w_mag_b = w_neg_b ? -bus.rs2_i : bus.rs2_i;
        w_div0  = is_div(w_op) && (bus.rs2_i == '0);
        w_ovf   = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                  (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (bus.rs2_i == '1);
        w_special = w_div0 | w_ovf;
        if (is_rem(w_op))
            w_special_res = w_div0 ? bus.rs1_i : '0;
        else
            w_special_res = w_div0 ? '1 : bus.rs1_i;
        w_accept = bus.start_i && !bus.kill_i &&
                   (r_state == S_IDLE);
    end

    // acc = {partial hi, multiplier} / {remainder, dividend->quotient}
    always_comb begin
        w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};
        w_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
        if (w_trial[XLEN])
            w_div_nxt = {r_acc[2*XLEN-2:0], 1'b0};
        else
            w_div_nxt = {w_trial[XLEN-1:0],
                         r_acc[XLEN-2:0], 1'b1};
    end

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .i_acc    (r_acc),
        .i_neg_a  (r_neg_a),
        .i_neg_b  (r_neg_b),
        .i_op     (r_op),
        .o_result (w_fix)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)
                        w_next = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == '0) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (bus.result_ready_i) w_next = S_IDLE;
        endcase
        if (bus.kill_i) w_next = S_IDLE;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MUL;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= w_op;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
                r_cnt   <= CW'(XLEN-1);
                if (is_div(w_op)) begin
                    r_opnd <= w_mag_b;
                    r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                end else begin
                    r_opnd <= w_mag_a;
                    r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                end
                if (w_special) r_result <= w_special_res;
            end else if (!bus.kill_i) begin
                if (r_state == S_CALC) begin
                    r_acc <= is_div(r_op) ? w_div_nxt : w_mul_nxt;
                    r_cnt <= r_cnt - 1'b1;
                end else if (r_state == S_FIX) begin
                    r_result <= w_fix;
                end
            end
        end
    end

    assign bus.ready_o  = (r_state == S_IDLE);
    assign bus.valid_o  = (r_state == S_DONE);
    assign bus.result_o = r_result;
endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter at XLEN=32.
module tb_muldiv_iter;
    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    muldiv_if #(.XLEN(32)) bus();

    muldiv_iter #(.XLEN(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(
        logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        exp_t e;
        e.res = model(op, a, b);
        e.lat = (op[2] && (b == 0 || (!op[0] &&
                 a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 34;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit tmo);
        lat = 1;
        tmo = 1'b0;
        while (!bus.valid_o && !tmo) begin
            @(posedge clk);
            #1 lat++;
            if (lat > 200) tmo = 1'b1;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.result_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.result_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 ||
            bus.result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset: ready=%b valid=%b result=%h want 1 0 0",
                     bus.ready_o, bus.valid_o, bus.result_o);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  ops[4] = '{3'd1, 3'd0, 3'd3, 3'd2};
        logic [31:0] as[4]  = '{32'hFFFFFFFE, 32'hFFFFFFFE,
                                32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs[4]  = '{32'h3, 32'h3,
                                32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] want[4] = '{32'hFFFFFFFF, 32'hFFFFFFFA,
                                 32'hFFFFFFFE, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            int lat;
            bit tmo;
            exp_t e;
            issue(ops[i], as[i], bs[i]);
            wait_valid(lat, tmo);
            e = sb_q.pop_front();
            checks++;
            if (tmo || bus.result_o !== want[i] || e.res !== want[i]) begin
                failures++;
                $display("FAIL mul[%0d]: got %h want %h (model %h)",
                         i, bus.result_o, want[i], e.res);
            end
            checks++;
            if (lat !== e.lat) begin
                failures++;
                $display("FAIL mul_lat[%0d]: got %0d want %0d",
                         i, lat, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as[4]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7};
        logic [31:0] want[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd3, 32'd1};
        for (int i = 0; i < 4; i++) begin
            int lat;
            bit tmo;
            exp_t e;
            issue(ops[i], as[i], 32'd2);
            wait_valid(lat, tmo);
            e = sb_q.pop_front();
            checks++;
            if (tmo || bus.result_o !== want[i] || e.res !== want[i]) begin
                failures++;
                $display("FAIL div[%0d]: got %h want %h (model %h)",
                         i, bus.result_o, want[i], e.res);
            end
            checks++;
            if (lat !== e.lat) begin
                failures++;
                $display("FAIL div_lat[%0d]: got %0d want %0d",
                         i, lat, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops[4] = '{3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] want[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            int lat;
            bit tmo;
            exp_t e;
            issue(ops[i], as[i], bs[i]);
            wait_valid(lat, tmo);
            e = sb_q.pop_front();
            checks++;
            if (tmo || bus.result_o !== want[i] || e.res !== want[i]) begin
                failures++;
                $display("FAIL special[%0d]: got %h want %h (model %h)",
                         i, bus.result_o, want[i], e.res);
            end
            checks++;
            if (lat !== 1) begin
                failures++;
                $display("FAIL special_lat[%0d]: got %0d want 1", i, lat);
            end
            consume();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int          lat;
            bit          tmo;
            exp_t        e;
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'($urandom_range(1, 100)) : $urandom;
            issue(op, a, b);
            wait_valid(lat, tmo);
            e = sb_q.pop_front();
            checks++;
            if (tmo || bus.result_o !== e.res || lat !== e.lat) begin
                failures++;
                $display("FAIL rand op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                         op, a, b, bus.result_o, lat, e.res, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] as[3] = '{32'd123456, 32'hFFFF0000, 32'd1000};
        logic [2:0]  ops[3] = '{3'd0, 3'd3, 3'd5};
        for (int i = 0; i < 3; i++) begin
            int   lat;
            bit   tmo;
            exp_t e;
            checks++;
            if (bus.ready_o !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.ready_o);
            end
            issue(ops[i], as[i], 32'd77);
            wait_valid(lat, tmo);
            e = sb_q.pop_front();
            checks++;
            if (tmo || bus.result_o !== e.res || lat !== e.lat) begin
                failures++;
                $display("FAIL b2b[%0d]: got %h lat %0d want %h lat %0d",
                         i, bus.result_o, lat, e.res, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        bit   tmo;
        int   bad;
        exp_t e;
        issue(3'd5, 32'd100, 32'd7);
        wait_valid(lat, tmo);
        e = sb_q.pop_front();
        checks++;
        if (tmo || bus.result_o !== 32'd14 || e.res !== 32'd14) begin
            failures++;
            $display("FAIL bp_result: got %h want 0000000e", bus.result_o);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 ||
                bus.result_o !== e.res) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        end
        consume();
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: ready=%b valid=%b want 1 0",
                     bus.ready_o, bus.valid_o);
        end
    endtask

    task automatic test_kill();
        int   lat;
        bit   tmo;
        int   seen;
        exp_t e;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.kill_i  = 1'b1;
        bus.op_i    = 3'd4;
        bus.rs1_i   = 32'd50;
        bus.rs2_i   = 32'd3;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b1) begin
            failures++;
            $display("FAIL kill_idle: ready=%b want 1", bus.ready_o);
        end
        @(negedge clk);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) bus.kill_i = 1'b1;
        @(posedge clk);
        #1 bus.kill_i = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL kill_calc: ready=%b valid=%b want 1 0",
                     bus.ready_o, bus.valid_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (bus.valid_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL kill_novalid: valid seen %0d cycles want 0", seen);
        end
        issue(3'd0, 32'd6, 32'd7);
        wait_valid(lat, tmo);
        e = sb_q.pop_front();
        checks++;
        if (tmo || bus.result_o !== 32'd42 || lat !== e.lat) begin
            failures++;
            $display("FAIL kill_after: got %h lat %0d want 0000002a lat %0d",
                     bus.result_o, lat, e.lat);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int   lat;
        bit   tmo;
        exp_t e;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.rs1_i   = 32'd3;
        bus.rs2_i   = 32'd5;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 ||
            bus.result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: ready=%b valid=%b result=%h want 1 0 0",
                     bus.ready_o, bus.valid_o, bus.result_o);
        end
        @(negedge clk) rst = 1'b0;
        issue(3'd5, 32'd7, 32'd2);
        wait_valid(lat, tmo);
        e = sb_q.pop_front();
        checks++;
        if (tmo || bus.result_o !== 32'd3 || lat !== e.lat) begin
            failures++;
            $display("FAIL reset_after: got %h lat %0d want 00000003 lat %0d",
                     bus.result_o, lat, e.lat);
        end
        consume();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.start_i        = 1'b0;
        bus.kill_i         = 1'b0;
        bus.result_ready_i = 1'b0;
        bus.op_i           = 3'd0;
        bus.rs1_i          = '0;
        bus.rs2_i          = '0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_kill();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative, parametrised RV M-extension execution unit: one multiply or divide in flight, radix-2 shift-add multiply and restoring divide on operand magnitudes, followed by a dedicated sign-correction cycle. Sits in the execute stage beside the ALU. The core issues one request through a valid/ready pair and stalls until the result handshake completes. Generalises the fixed 32-bit combinational output stage to any XLEN, adds a sequential datapath and a kill path, and handles the spec-mandated divide-by-zero and overflow results.

## Interface
- XLEN, 32, operand/result width; even, ≥ 4
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  request valid; accepted when start_i && ready_o
- ready_o  out  1  unit idle, can accept a request
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  in  XLEN  operand A / dividend
- rs2_i  in  XLEN  operand B / divisor
- kill_i  in  1  abort the in-flight operation (pipeline flush)
- valid_o  out  1  result_o holds the final result
- result_ready_i  in  1  consumer accepts the result
- result_o  out  XLEN  result

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: ready_o=1. On accept, latch op, the sign of each operand, and magnitudes:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Magnitude = two's-complement negation when the operand is signed and negative.
- Special cases on accept, IDLE → DONE directly:
  - Divide by zero (rs2==0, div/rem op): quotient = all ones; remainder = rs1 unchanged.
  - Signed overflow (DIV/REM, rs1 = 1<<(XLEN-1), rs2 = all ones): quotient = rs1; remainder = 0.
- Otherwise IDLE → CALC, counter = XLEN-1.
- CALC, one iteration per cycle, 2·XLEN-bit accumulator:
  - Multiply: add/shift.
  - Divide: shift, trial subtract, set quotient bit.
  - Counter reaching 0 → FIX.
- FIX, sign correction:
  - MUL family: negate the 2·XLEN product iff exactly one operand was treated as negative. MUL returns [XLEN-1:0]; MULH/MULHSU/MULHU return [2XLEN-1:XLEN].
  - Quotient: negated iff operand signs differ (signed ops only).
  - Remainder: takes the dividend's sign.
  - FIX → DONE.
- DONE: valid_o=1, result_o stable. Leave for IDLE on result_ready_i.
- kill_i has priority over every other event in any state: next state IDLE, valid_o=0, no result produced. kill_i in IDLE together with start_i means the request is not accepted.

## Timing
- Reset: state IDLE; ready_o=1, valid_o=0, result_o=0, counter=0, accumulators=0.
- Accept at edge N.
- Normal op:
  - CALC during N+1 … N+XLEN.
  - FIX at N+XLEN+1.
  - valid_o high from edge N+XLEN+2. Latency XLEN+2 cycles (34 at XLEN=32).
- Special case: valid_o high from edge N+1 (latency 1).
- valid_o holds with result_o constant until result_ready_i is sampled high. valid_o=0 and ready_o=1 on the following cycle; no same-cycle accept while in DONE.
- ready_o=0 in CALC, FIX and DONE.
- Reset mid-operation: immediate return to reset values.
- result_o is only meaningful while valid_o=1; between operations it retains its last value.

## Structure
- Package muldiv_pkg holds:
  - the op_e enum (funct3 encodings above);
  - the state_e enum;
  - helper functions is_div(op) and is_signed_a/b(op).
- One sub-module, muldiv_signfix (combinational), parametrised by XLEN. Inputs: raw product or quotient/remainder, latched signs, op. Output: corrected result. It is used in FIX and replaces the old output stage.
- Counter width $clog2(XLEN).

## Test plan
All values at XLEN=32.
- MULH rs1=0xFFFFFFFE (−2), rs2=3 → 0xFFFFFFFF. MUL same operands → 0xFFFFFFFA. Each valid exactly 34 cycles after accept.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU same operands → 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 7/2 → 3. REMU 7/2 → 1.
- DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. All four valid 1 cycle after accept.
- Back-pressure: hold result_ready_i low 10 cycles after valid_o. Required: result_o and valid_o stable throughout, ready_o=0; on release, ready_o=1 the next cycle.
- kill_i at CALC cycle 5 of a DIV. Required: ready_o=1 next cycle, valid_o never asserted; a following MUL 6×7 returns 42. reset_i pulsed mid-CALC → all outputs at reset values immediately.
